line_buf_sched: RTL and testbench
=================================

LINE_BUF_SCHED -- requirements
Module: line_buf_sched

Interface
REQ-001 Parameters SHALL be, one per line, name, default, meaning:
- HSIZE 1280: active pixels per line.
- HFP 1390: hsync assert column.
- HSP 1430: hsync deassert column.
- HMAX 1650: total columns.
- VSIZE 720: active lines.
- VFP 725: vsync assert line.
- VSP 730: vsync deassert line.
- VMAX 750: total lines.

REQ-002 Ports SHALL be, one per line, name, direction, width, meaning:
- i_vid_clk  in  1  sole clock.
- i_rst  in  1  reset.
- i_sof  in  1  one-cycle frame-start pulse, already synchronous to i_vid_clk.
- i_line_done  in  1  one-cycle pulse: writer finished a full line into bank o_wr_bank.
- o_wr_bank  out  1  bank the writer fills next.
- o_rd_en  out  1  line-buffer read enable.
- o_rd_bank  out  1  bank being read.
- o_rd_addr  out  11  pixel address within bank.
- o_vid_hsync  out  1  active-low hsync.
- o_vid_vsync  out  1  active-low vsync.
- o_vid_active_video  out  1  active region.
- o_hdata  out  11  column of current output pixel.
- o_vdata  out  10  line of current output pixel.
- o_locked  out  1  high in RUN.
- o_underflow  out  1  sticky: active line started with read bank empty.
- o_overflow  out  1  sticky: line written into a bank still full.

REQ-003 The block SHALL use one clock, i_vid_clk; i_rst SHALL be synchronous and active-high.

Function
REQ-004 FSM SHALL have states IDLE, WAIT_FILL and RUN.
- IDLE→WAIT_FILL on i_sof.
- WAIT_FILL→RUN on first i_line_done.
- Any state→WAIT_FILL on i_sof.

REQ-005 In IDLE and WAIT_FILL, hdata and vdata SHALL be held at 0, o_rd_en=0, syncs=1, o_vid_active_video=0.

REQ-006 In RUN, hdata SHALL count 0..HMAX-1 and wrap to 0; vdata SHALL increment when hdata==HMAX-1 and wrap to 0 after VMAX-1. Counting SHALL begin at hdata=0, vdata=0 on the cycle after entry to RUN.

REQ-007 The block SHALL keep a two-bit full flag, one per bank.
- i_line_done SHALL set full[o_wr_bank] and toggle o_wr_bank.
- If full[o_wr_bank] is already 1, o_overflow SHALL set; the write is still accepted.

REQ-008 At hdata==0 with vdata<VSIZE, if full[rd_bank]==1 the line SHALL be read: o_rd_en high for columns 0..HSIZE-1, o_rd_addr=hdata.

REQ-009 At hdata==0 with vdata<VSIZE, if full[rd_bank]==0, o_underflow SHALL set, o_rd_en SHALL stay 0 for that line, and rd_bank SHALL not toggle. Timing SHALL continue unchanged.

REQ-010 At hdata==HSIZE-1 of a read line, full[rd_bank] SHALL clear and rd_bank SHALL toggle.
- Set and clear on the same bank in the same cycle: the set wins, and o_overflow sets.

REQ-011 Latency:
- o_rd_en, o_rd_addr and o_rd_bank SHALL be registered one cycle after the counters.
- o_vid_hsync, o_vid_vsync, o_vid_active_video, o_hdata and o_vdata SHALL be registered two cycles after the counters, so that data from a one-cycle-latency RAM aligns with o_vid_active_video.

REQ-012 Sync and active definitions:
- hsync=0 iff HFP<=hdata<HSP.
- vsync=0 iff VFP<=vdata<VSP.
- active=1 iff hdata<HSIZE and vdata<VSIZE.

REQ-013 On i_sof in RUN, the following SHALL clear: counters, full flags, o_wr_bank, rd_bank and pipeline valids. Sticky flags SHALL be kept. i_sof coincident with i_line_done: i_sof wins and the line is discarded.

REQ-014 i_line_done in IDLE SHALL be ignored.

Reset
REQ-015 On i_rst, state SHALL go to IDLE, and all counters, flags, banks and outputs SHALL go to 0, except o_vid_hsync=1 and o_vid_vsync=1.

REQ-016 i_rst asserted mid-line SHALL take effect on the next edge; the sticky flags are cleared only by i_rst.

Structure
REQ-017 The timing defaults and the FSM state encoding SHALL live in shared package vid_timing_pkg.

REQ-018 The h/v counter with sync decode SHALL be sub-module vid_timing_cnt, with enable and clear inputs; the FSM and bank flags SHALL stay in line_buf_sched.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- Reset, then i_sof, then i_line_done at cycle 10 → o_locked=1 at cycle 11; o_rd_en=1 two cycles after RUN entry with o_rd_addr=0, o_rd_bank=0; o_vid_active_video=1 one cycle later.
- i_line_done every 1650 cycles → no underflow/overflow over 750 lines; hsync low for 40 cycles per line; vsync low for 5 lines.
- No i_line_done after the first → line 1 sets o_underflow, o_rd_en stays 0 for line 1, syncs keep toggling.
- Three i_line_done pulses before line 0 ends → o_overflow=1 on the third.
- i_sof at hdata=600, vdata=300 → o_locked=0, counters 0, full=00; next i_line_done resumes RUN.
- i_rst at hdata=700 while reading → all outputs reset on the next edge, hsync=1, o_underflow=0.

Source files
------------

// File: rtl/vid_timing_pkg.sv
// vid_timing_pkg: default video timing and scheduler state encoding
package vid_timing_pkg;
  localparam int HSIZE_D = 1280;
  localparam int HFP_D   = 1390;
  localparam int HSP_D   = 1430;
  localparam int HMAX_D  = 1650;
  localparam int VSIZE_D = 720;
  localparam int VFP_D   = 725;
  localparam int VSP_D   = 730;
  localparam int VMAX_D  = 750;
  typedef enum logic [1:0] {IDLE, WAIT_FILL, RUN} state_t;
endpackage

// File: rtl/vid_timing_cnt.sv
// vid_timing_cnt: horizontal/vertical raster counter with sync and active decode
module vid_timing_cnt import vid_timing_pkg::*; #(
  parameter int HSIZE = HSIZE_D,
  parameter int HFP   = HFP_D,
  parameter int HSP   = HSP_D,
  parameter int HMAX  = HMAX_D,
  parameter int VSIZE = VSIZE_D,
  parameter int VFP   = VFP_D,
  parameter int VSP   = VSP_D,
  parameter int VMAX  = VMAX_D
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        clr,
  output logic [10:0] hdata,
  output logic [9:0]  vdata,
  output logic        hsync,
  output logic        vsync,
  output logic        active
);
  localparam logic [10:0] H_LAST = 11'(HMAX - 1);
  localparam logic [10:0] H_SZ   = 11'(HSIZE);
  localparam logic [10:0] H_FP   = 11'(HFP);
  localparam logic [10:0] H_SP   = 11'(HSP);
  localparam logic [9:0]  V_LAST = 10'(VMAX - 1);
  localparam logic [9:0]  V_SZ   = 10'(VSIZE);
  localparam logic [9:0]  V_FP   = 10'(VFP);
  localparam logic [9:0]  V_SP   = 10'(VSP);
  // raster position advances only while enabled; clear restarts the frame at 0,0
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      hdata <= '0;
      vdata <= '0;
    end else if (en) begin
      hdata <= (hdata == H_LAST) ? '0 : hdata + 11'd1;
      if (hdata == H_LAST) vdata <= (vdata == V_LAST) ? '0 : vdata + 10'd1;
    end
  end
  // active-low syncs and active window decoded from the current position
  always_comb begin
    hsync  = !(hdata >= H_FP && hdata < H_SP);
    vsync  = !(vdata >= V_FP && vdata < V_SP);
    active = hdata < H_SZ && vdata < V_SZ;
  end
endmodule

// File: rtl/line_buf_sched.sv
// line_buf_sched: ping-pong line buffer scheduler driving a video raster
module line_buf_sched import vid_timing_pkg::*; #(
  parameter int HSIZE = HSIZE_D,
  parameter int HFP   = HFP_D,
  parameter int HSP   = HSP_D,
  parameter int HMAX  = HMAX_D,
  parameter int VSIZE = VSIZE_D,
  parameter int VFP   = VFP_D,
  parameter int VSP   = VSP_D,
  parameter int VMAX  = VMAX_D
) (
  input  logic        i_vid_clk,
  input  logic        i_rst,
  input  logic        i_sof,
  input  logic        i_line_done,
  output logic        o_wr_bank,
  output logic        o_rd_en,
  output logic        o_rd_bank,
  output logic [10:0] o_rd_addr,
  output logic        o_vid_hsync,
  output logic        o_vid_vsync,
  output logic        o_vid_active_video,
  output logic [10:0] o_hdata,
  output logic [9:0]  o_vdata,
  output logic        o_locked,
  output logic        o_underflow,
  output logic        o_overflow
);
  localparam logic [10:0] H_SZ   = 11'(HSIZE);
  localparam logic [10:0] H_LAST = 11'(HSIZE - 1);
  localparam logic [9:0]  V_SZ   = 10'(VSIZE);
  state_t state, state_n;
  logic cnt_run, rd_bank, rd_line;
  logic [1:0] full, set_m, clr_m;
  logic [10:0] hdata, hd1;
  logic [9:0] vdata, vd1;
  logic hsync, vsync, active, hs1, vs1, act1;
  logic act_ln, line_start, line_rd, rd_now, rd_last, wr;
  vid_timing_cnt #(
    .HSIZE(HSIZE), .HFP(HFP), .HSP(HSP), .HMAX(HMAX),
    .VSIZE(VSIZE), .VFP(VFP), .VSP(VSP), .VMAX(VMAX)
  ) u_cnt (
    .clk(i_vid_clk),
    .rst(i_rst),
    .en(cnt_run),
    .clr(i_sof),
    .hdata(hdata),
    .vdata(vdata),
    .hsync(hsync),
    .vsync(vsync),
    .active(active)
  );
  assign o_locked = state == RUN;
  // frame start always restarts the fill wait; the first finished line starts the raster
  always_comb state_n = i_sof ? WAIT_FILL : (state == WAIT_FILL && i_line_done) ? RUN : state;
  // state register
  always_ff @(posedge i_vid_clk) state <= i_rst ? IDLE : state_n;
  // read/write decisions; a line's read verdict is taken at column 0 and held for the line
  always_comb begin
    act_ln     = cnt_run && vdata < V_SZ;
    line_start = act_ln && hdata == '0;
    line_rd    = (hdata == '0) ? full[rd_bank] : rd_line;
    rd_now     = act_ln && hdata < H_SZ && line_rd;
    rd_last    = rd_now && hdata == H_LAST;
    wr         = i_line_done && state != IDLE && !i_sof;
    set_m      = wr ? 2'b01 << o_wr_bank : 2'b00;
    clr_m      = rd_last ? 2'b01 << rd_bank : 2'b00;
  end
  // bank flags and pointers; a set beats a clear on the same bank, sticky errors survive frame start
  always_ff @(posedge i_vid_clk) begin
    if (i_rst) begin
      cnt_run     <= 1'b0;
      full        <= '0;
      o_wr_bank   <= 1'b0;
      rd_bank     <= 1'b0;
      rd_line     <= 1'b0;
      o_underflow <= 1'b0;
      o_overflow  <= 1'b0;
    end else begin
      cnt_run     <= !i_sof && state == RUN;
      full        <= i_sof ? '0 : (full & ~clr_m) | set_m;
      o_wr_bank   <= !i_sof && (o_wr_bank ^ wr);
      rd_bank     <= !i_sof && (rd_bank ^ rd_last);
      rd_line     <= !i_sof && (line_start ? full[rd_bank] : rd_line);
      o_underflow <= o_underflow | (line_start && !full[rd_bank] && !i_sof);
      o_overflow  <= o_overflow | (wr && full[o_wr_bank]);
    end
  end
  // read port one cycle behind the counters, video two cycles behind to match RAM latency
  always_ff @(posedge i_vid_clk) begin
    if (i_rst || i_sof) begin
      o_rd_en            <= 1'b0;
      o_rd_addr          <= '0;
      o_rd_bank          <= 1'b0;
      hd1                <= '0;
      vd1                <= '0;
      hs1                <= 1'b1;
      vs1                <= 1'b1;
      act1               <= 1'b0;
      o_hdata            <= '0;
      o_vdata            <= '0;
      o_vid_hsync        <= 1'b1;
      o_vid_vsync        <= 1'b1;
      o_vid_active_video <= 1'b0;
    end else begin
      o_rd_en            <= rd_now;
      o_rd_addr          <= rd_now ? hdata : '0;
      o_rd_bank          <= rd_bank;
      hd1                <= hdata;
      vd1                <= vdata;
      hs1                <= hsync;
      vs1                <= vsync;
      act1               <= active && cnt_run;
      o_hdata            <= hd1;
      o_vdata            <= vd1;
      o_vid_hsync        <= hs1;
      o_vid_vsync        <= vs1;
      o_vid_active_video <= act1;
    end
  end
endmodule

// File: tb/tb_line_buf_sched.sv
// tb_line_buf_sched: directed table, corner sequences and random run against a raster model
module tb_line_buf_sched;
  localparam int HSIZE = 16, HFP = 20, HSP = 24, HMAX = 30;
  localparam int VSIZE = 8, VFP = 10, VSP = 12, VMAX = 14;
  logic clk = 1'b0, rst = 1'b1, sof = 1'b0, ld = 1'b0;
  logic o_wr_bank, o_rd_en, o_rd_bank, o_vid_hsync, o_vid_vsync, o_vid_active_video;
  logic o_locked, o_underflow, o_overflow;
  logic [10:0] o_rd_addr, o_hdata;
  logic [9:0] o_vdata;
  int total = 0, bad = 0;
  line_buf_sched #(
    .HSIZE(HSIZE), .HFP(HFP), .HSP(HSP), .HMAX(HMAX),
    .VSIZE(VSIZE), .VFP(VFP), .VSP(VSP), .VMAX(VMAX)
  ) dut (
    .i_vid_clk(clk), .i_rst(rst), .i_sof(sof), .i_line_done(ld),
    .o_wr_bank(o_wr_bank), .o_rd_en(o_rd_en), .o_rd_bank(o_rd_bank), .o_rd_addr(o_rd_addr),
    .o_vid_hsync(o_vid_hsync), .o_vid_vsync(o_vid_vsync), .o_vid_active_video(o_vid_active_video),
    .o_hdata(o_hdata), .o_vdata(o_vdata), .o_locked(o_locked),
    .o_underflow(o_underflow), .o_overflow(o_overflow)
  );
  always #5 clk = ~clk;
  typedef struct {int h; int v; bit hs; bit vs; bit act;} vid_t;
  typedef struct {bit s; bit l; bit lk; bit en; int addr; bit bank; bit act; int hd;} vec_t;
  int m_st, m_t, m_wr, m_rd, x_addr, x_bank;
  bit m_cnt, m_line, m_uf, m_of, x_rd_en;
  logic [1:0] m_full;
  vid_t x_v1, x_vid;
  function automatic vid_t idle_vid();
    vid_t r;
    r.h = 0; r.v = 0; r.hs = 1'b1; r.vs = 1'b1; r.act = 1'b0;
    return r;
  endfunction
  task automatic mclear();
    m_cnt = 0; m_t = 0; m_full = '0; m_wr = 0; m_rd = 0; m_line = 0;
    x_rd_en = 0; x_addr = 0; x_bank = 0; x_v1 = idle_vid(); x_vid = idle_vid();
  endtask
  task automatic mstep(input bit s, input bit l, input bit r);
    int h, v, old_st;
    bit en;
    vid_t cv;
    if (r) begin
      mclear(); m_st = 0; m_uf = 0; m_of = 0;
    end else if (s) begin
      mclear(); m_st = 1;
    end else begin
      old_st = m_st;
      h = m_t % HMAX;
      v = (m_t / HMAX) % VMAX;
      cv = idle_vid();
      en = 0;
      if (m_cnt) begin
        cv.h = h; cv.v = v;
        cv.hs = !(h >= HFP && h < HSP);
        cv.vs = !(v >= VFP && v < VSP);
        cv.act = h < HSIZE && v < VSIZE;
        if (v < VSIZE && h < HSIZE) begin
          if (h == 0) begin
            m_line = m_full[m_rd];
            if (!m_line) m_uf = 1;
          end
          en = m_line;
        end
      end
      x_vid = x_v1; x_v1 = cv;
      x_rd_en = en; x_addr = en ? h : 0; x_bank = m_rd;
      if (l && m_st != 0 && m_full[m_wr]) m_of = 1;
      if (en && h == HSIZE - 1) begin
        m_full[m_rd] = 1'b0;
        m_rd ^= 1;
      end
      if (l && m_st != 0) begin
        m_full[m_wr] = 1'b1;
        m_wr ^= 1;
        if (m_st == 1) m_st = 2;
      end
      if (m_cnt) m_t++;
      m_cnt = old_st == 2;
    end
  endtask
  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s at %0t: got=%0d want=%0d", nm, $time, a, e);
    end
  endtask
  task automatic check_all();
    chk("locked", o_locked, m_st == 2);
    chk("wr_bank", o_wr_bank, m_wr);
    chk("rd_en", o_rd_en, x_rd_en);
    chk("rd_addr", o_rd_addr, x_addr);
    chk("rd_bank", o_rd_bank, x_bank);
    chk("hsync", o_vid_hsync, x_vid.hs);
    chk("vsync", o_vid_vsync, x_vid.vs);
    chk("active", o_vid_active_video, x_vid.act);
    chk("hdata", o_hdata, x_vid.h);
    chk("vdata", o_vdata, x_vid.v);
    chk("underflow", o_underflow, m_uf);
    chk("overflow", o_overflow, m_of);
  endtask
  task automatic cyc(input bit s, input bit l, input bit r);
    @(negedge clk);
    sof = s; ld = l; rst = r;
    @(posedge clk);
    mstep(s, l, r);
    #1 check_all();
  endtask
  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0);
  endtask
  function automatic bit want_ld();
    return m_cnt && m_t % HMAX == 5 && ((m_t / HMAX + 1) % VMAX) < VSIZE;
  endfunction
  task automatic run_to(input int h, input int v, input bit feed, input string nm);
    int n;
    n = 0;
    while (!(m_cnt && m_t % HMAX == h && (m_t / HMAX) % VMAX == v) && n < 3000) begin
      cyc(0, feed && want_ld(), 0);
      n++;
    end
    chk({nm, "_reached"}, n < 3000, 1);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    vec_t tv[14];
    int hs_low, vs_low, rd_cnt, r_s, r_l, r_r;
    tv[0] = '{1, 0, 0, 0, 0, 0, 0, 0};
    for (int i = 1; i < 9; i++) tv[i] = '{0, 0, 0, 0, 0, 0, 0, 0};
    tv[9]  = '{0, 1, 1, 0, 0, 0, 0, 0};
    tv[10] = '{0, 0, 1, 0, 0, 0, 0, 0};
    tv[11] = '{0, 0, 1, 1, 0, 0, 0, 0};
    tv[12] = '{0, 0, 1, 1, 1, 0, 1, 0};
    tv[13] = '{0, 0, 1, 1, 2, 0, 1, 1};
    mclear(); m_st = 0; m_uf = 0; m_of = 0;
    cyc(0, 0, 1);
    chk("rst_hsync", o_vid_hsync, 1);
    chk("rst_vsync", o_vid_vsync, 1);
    chk("rst_locked", o_locked, 0);
    chk("rst_rd_en", o_rd_en, 0);
    chk("rst_flags", {o_underflow, o_overflow}, 0);
    cyc(1, 1, 0);
    chk("idle_ld_ignored", o_wr_bank, 0);
    cyc(0, 0, 1);
    for (int i = 0; i < 14; i++) begin
      cyc(tv[i].s, tv[i].l, 0);
      chk($sformatf("tv%0d_locked", i), o_locked, tv[i].lk);
      chk($sformatf("tv%0d_rd_en", i), o_rd_en, tv[i].en);
      chk($sformatf("tv%0d_rd_addr", i), o_rd_addr, tv[i].addr);
      chk($sformatf("tv%0d_rd_bank", i), o_rd_bank, tv[i].bank);
      chk($sformatf("tv%0d_active", i), o_vid_active_video, tv[i].act);
      chk($sformatf("tv%0d_hdata", i), o_hdata, tv[i].hd);
    end
    hs_low = 0; vs_low = 0; rd_cnt = 0;
    for (int i = 0; i < VMAX * HMAX; i++) begin
      cyc(0, want_ld(), 0);
      hs_low += int'(!o_vid_hsync);
      vs_low += int'(!o_vid_vsync);
      rd_cnt += int'(o_rd_en);
    end
    chk("steady_hs_low", hs_low, VMAX * (HSP - HFP));
    chk("steady_vs_low", vs_low, HMAX * (VSP - VFP));
    chk("steady_rd_cnt", rd_cnt, VSIZE * HSIZE);
    chk("steady_flags", {o_underflow, o_overflow}, 0);
    cyc(0, 0, 1);
    cyc(1, 0, 0);
    cyc(0, 1, 0);
    hs_low = 0; rd_cnt = 0;
    for (int i = 1; i <= 2 * HMAX + 4; i++) begin
      cyc(0, 0, 0);
      hs_low += int'(!o_vid_hsync);
      rd_cnt += int'(o_rd_en);
    end
    chk("uf_flag", o_underflow, 1);
    chk("uf_rd_cnt", rd_cnt, HSIZE);
    chk("uf_hs_low", hs_low, 2 * (HSP - HFP));
    chk("uf_no_ovf", o_overflow, 0);
    cyc(0, 0, 1);
    cyc(1, 0, 0);
    cyc(0, 1, 0);
    run(3);
    cyc(0, 1, 0);
    chk("ovf_second", o_overflow, 0);
    run(3);
    cyc(0, 1, 0);
    chk("ovf_third", o_overflow, 1);
    cyc(0, 0, 1);
    cyc(1, 0, 0);
    cyc(0, 1, 0);
    run_to(10, 5, 1, "sof_mid");
    cyc(1, 0, 0);
    chk("sof_locked", o_locked, 0);
    chk("sof_cnt", {dut.hdata, 1'b0, dut.vdata}, 0);
    chk("sof_full", dut.full, 0);
    chk("sof_wr_bank", o_wr_bank, 0);
    chk("sof_rd_en", o_rd_en, 0);
    run(2);
    cyc(0, 1, 0);
    chk("sof_relock", o_locked, 1);
    run(2);
    chk("sof_resume_rd", {o_rd_en, o_rd_bank, o_rd_addr}, {2'b10, 11'd0});
    chk("sof_no_flags", {o_underflow, o_overflow}, 0);
    cyc(0, 0, 1);
    cyc(1, 0, 0);
    cyc(0, 1, 0);
    run_to(5, 1, 0, "rst_line1");
    cyc(0, 1, 0);
    run_to(12, 2, 0, "rst_mid");
    chk("rst_mid_uf", o_underflow, 1);
    chk("rst_mid_reading", o_rd_en, 1);
    cyc(0, 0, 1);
    chk("rst_mid_hsync", o_vid_hsync, 1);
    chk("rst_mid_vsync", o_vid_vsync, 1);
    chk("rst_mid_uf_clr", o_underflow, 0);
    chk("rst_mid_outs", {o_locked, o_rd_en, o_rd_addr, o_hdata, o_vdata, o_vid_active_video}, 0);
    cyc(1, 0, 0);
    for (int i = 0; i < 6000; i++) begin
      r_s = int'($urandom_range(0, 399) == 0);
      r_l = int'($urandom_range(0, 24) == 0 || want_ld());
      r_r = int'($urandom_range(0, 2999) == 0);
      cyc(r_s[0], r_l[0], r_r[0]);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
